// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned CNT_W      = 4;

  // Low byte-address bits that must be zero for a word access.
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-lane synchronous write and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [BYTE_LANES-1:0] be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int unsigned i = 0; i < BYTE_LANES; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, commits and pulses a response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [BYTE_LANES-1:0] req_be_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  commit;
  logic                  addr_err;
  logic [31:0]           addr_hi;
  logic [DATA_W-1:0]     arr_rdata;

  assign addr_hi  = addr_q >> (ADDR_W + 2);
  assign addr_err = (|(addr_q & ALIGN_MASK)) || (|addr_hi);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          be_d    = req_be_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          err_d   = addr_err;
          state_d = StResp;
        end
      end
      StResp: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Faulted requests never touch the array, so a bad store cannot alias a real word.
  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (commit && !addr_err && !rst_i),
    .we_i    (we_q),
    .addr_i  (addr_q[ADDR_W+1:2]),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign req_ready_o  = (state_q == StIdle) && !rst_i;
  assign resp_valid_o = (state_q == StResp);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the processor's data-memory request interface. It accepts one load or store request at a time, holds it for a programmable number of wait cycles, then commits the store or returns the load data with a one-cycle response pulse. The processor's memory stage (or a stall unit in front of it) drives requests and freezes the pipeline until the response arrives. The block owns the word-addressed data storage array.

Parameters:
ADDR_W, 10, word-address bits; array depth = 2**ADDR_W words.
DATA_W, 32, data word width; must equal 32 (4 byte lanes).
LATENCY, 2, wait cycles from request accept to response; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_be  in  4  byte-lane write enables; bit i enables wdata[8i+7:8i]. Ignored on loads.
req_wdata  in  DATA_W  store data.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  DATA_W  load data; 0 for stores and errors.
resp_err  out  1  request faulted; qualified by resp_valid.

Behaviour:
- Reset values: req_ready=0 while rst is high and 1 in the first cycle after release; resp_valid=0; resp_rdata=0; resp_err=0; FSM=IDLE; wait counter=0. Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. If req_valid is high at an edge, the request is accepted: latch we, addr, be and wdata; load counter=LATENCY-1; go to WAIT. req_ready=1 only in IDLE.
- WAIT: req_ready=0; inputs are ignored. At each edge, if counter≠0 then decrement it; else perform the commit and go to RESP.
- Commit (same edge RESP is entered):
  - Error check: resp_err=1 if addr[1:0]≠0 (misaligned) or addr[31:ADDR_W+2]≠0 (out of range).
  - Store with no error: write the lanes enabled by be at word addr[ADDR_W+1:2]. be=4'b0000 writes nothing but still responds.
  - Load with no error: resp_rdata = array word, read at this edge.
  - Any error: no write; resp_rdata=0.
- RESP: resp_valid=1 for exactly this cycle. req_ready=0. Next edge returns to IDLE and clears resp_valid, resp_rdata and resp_err.
- Latency: if a request is accepted at edge N, resp_valid is high in the cycle following edge N+LATENCY. Throughput is one request per LATENCY+2 cycles.
- Back-to-back store then load to the same word: the load returns the new data, since the store commits before the next accept.
- There is no response backpressure; the requester must sample resp_valid.
- Reset mid-operation (WAIT or RESP) returns to IDLE. A pending store is dropped with no partial write, and no response is produced.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - BYTE_LANES=4;
  - the alignment-mask constant;
  - the counter width constant CNT_W=4.
- One sub-module, dmem_array: DATA_W×2**ADDR_W storage with byte-enable synchronous write and synchronous read, one port. The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- Reset/idle: rst pulse mid-run. Required: req_ready=0 and resp_valid=0 during reset; req_ready=1 in the first cycle after release.
- Store-then-load, LATENCY=2: store addr=0x10, be=4'hF, wdata=0xDEADBEEF accepted at edge N; resp_valid high after edge N+2 with resp_err=0. Then load 0x10 returns resp_rdata=0xDEADBEEF with the same timing.
- Byte lanes: word 0x20 preset to 0x11223344; store be=4'b0101, wdata=0xAABBCCDD. A subsequent load of 0x20 returns 0x11BB33DD.
- Errors: load 0x22 (misaligned) and store 0x00001000 with ADDR_W=10 (out of range). Required: resp_err=1 and resp_rdata=0 for both; a later load of word 0 is unchanged.
- Busy handling: hold req_valid high continuously with alternating requests. Required: exactly one accept per LATENCY+2 cycles; req_ready=0 in WAIT and RESP; no request lost or duplicated.
- Reset mid-store: rst asserted one cycle after a store to 0x30 (data 0x12345678) is accepted. Required: no resp_valid; a post-reset load of 0x30 returns the prior value.
